// File: rtl/sync_w2r_status.sv
// Read-domain synchronizer for the Gray-coded write pointer of an async FIFO.
// It also produces registered fill/empty/almost-empty status and a sticky Gray-violation flag.
module sync_w2r_status #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   rptr_bin,
  input  logic                err_clr,
  output logic [ADDRSIZE:0]   rq_wptr_gray,
  output logic [ADDRSIZE:0]   rq_wptr_bin,
  output logic [ADDRSIZE:0]   rfill,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic                wptr_chg,
  output logic                gray_err
);

  localparam logic [ADDRSIZE:0] AE_TH = (ADDRSIZE+1)'(AE_THRESH);
  localparam logic [ADDRSIZE:0] ONE   = {{ADDRSIZE{1'b0}}, 1'b1};

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_w2r_status: SYNC_STAGES must be at least 2");
  end

  logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
  logic [ADDRSIZE:0] prev_q;
  logic [ADDRSIZE:0] fill_q,  fill_d;
  logic              empty_q, empty_d;
  logic              ae_q,    ae_d;
  logic              chg_q,   chg_d;
  logic              err_q,   err_d;
  logic [ADDRSIZE:0] diff;
  logic              violation;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rq_wptr_gray = sync_q[SYNC_STAGES-1];

  // Binary bit i is the parity of all Gray bits at or above i.
  always_comb begin
    rq_wptr_bin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) rq_wptr_bin[i] = ^(rq_wptr_gray >> i);
  end

  // More than one bit set in the step means the pointer was not captured as a Gray step.
  assign diff      = rq_wptr_gray ^ prev_q;
  assign violation = (diff & (diff - ONE)) != '0;

  always_comb begin
    fill_d  = rq_wptr_bin - rptr_bin;
    empty_d = (fill_d == '0);
    ae_d    = (fill_d <= AE_TH);
    chg_d   = (diff != '0);
    err_d   = err_q;
    if (violation)    err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      prev_q  <= '0;
      fill_q  <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= rq_wptr_gray;
      fill_q  <= fill_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      chg_q   <= chg_d;
      err_q   <= err_d;
    end
  end

  assign rfill         = fill_q;
  assign rempty        = empty_q;
  assign ralmost_empty = ae_q;
  assign wptr_chg      = chg_q;
  assign gray_err      = err_q;

endmodule

// File: tb/tb_sync_w2r_status.sv
// Bench for sync_w2r_status: a default instance (2 stages, threshold 1) and a
// 3-stage/threshold-4 instance share stimulus and are checked against a behavioural model.
module tb_sync_w2r_status;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic [4:0] wptr, rptr, wbin;
  logic       err_clr;

  logic [4:0] a_gray, a_bin, a_fill, b_gray, b_bin, b_fill;
  logic       a_empty, a_ae, a_chg, a_err, b_empty, b_ae, b_chg, b_err;

  int checks = 0;
  int errors = 0;

  always #5 rclk = ~rclk;

  sync_w2r_status #(.ADDRSIZE(4), .SYNC_STAGES(2), .AE_THRESH(1)) u_a (
    .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr), .rptr_bin(rptr), .err_clr(err_clr),
    .rq_wptr_gray(a_gray), .rq_wptr_bin(a_bin), .rfill(a_fill), .rempty(a_empty),
    .ralmost_empty(a_ae), .wptr_chg(a_chg), .gray_err(a_err)
  );

  sync_w2r_status #(.ADDRSIZE(4), .SYNC_STAGES(3), .AE_THRESH(4)) u_b (
    .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr), .rptr_bin(rptr), .err_clr(err_clr),
    .rq_wptr_gray(b_gray), .rq_wptr_bin(b_bin), .rfill(b_fill), .rempty(b_empty),
    .ralmost_empty(b_ae), .wptr_chg(b_chg), .gray_err(b_err)
  );

  // Behavioural model: hq holds wptr as sampled at each edge since reset, newest first.
  logic [4:0] hq[$];
  int         m_stages[2] = '{2, 3};
  int         m_thresh[2] = '{1, 4};
  logic [4:0] m_prev[2], m_fill[2];
  logic       m_empty[2], m_ae[2], m_chg[2], m_err[2];

  function automatic logic [4:0] gray2bin(input logic [4:0] g);
    for (int b = 0; b < 32; b++) begin
      if ((5'(b) ^ (5'(b) >> 1)) == g) return 5'(b);
    end
    return 5'd0;
  endfunction

  function automatic logic [4:0] rq_of(input int k);
    int s;
    s = m_stages[k];
    return (hq.size() >= s) ? hq[s-1] : 5'd0;
  endfunction

  task automatic model_reset();
    hq.delete();
    for (int k = 0; k < 2; k++) begin
      m_prev[k] = 5'd0; m_fill[k] = 5'd0; m_empty[k] = 1'b1;
      m_ae[k] = 1'b1; m_chg[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [4:0] og;
    if (!rrst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      og         = rq_of(k);
      m_fill[k]  = gray2bin(og) - rptr;
      m_empty[k] = (m_fill[k] == 5'd0);
      m_ae[k]    = (int'(m_fill[k]) <= m_thresh[k]);
      m_chg[k]   = (og != m_prev[k]);
      if ($countones(og ^ m_prev[k]) > 1) m_err[k] = 1'b1;
      else if (err_clr)                   m_err[k] = 1'b0;
      m_prev[k]  = og;
    end
    hq.push_front(wptr);
    if (hq.size() > 4) void'(hq.pop_back());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " a.gray"},  32'(a_gray),  32'(rq_of(0)));
    chk({tag, " a.bin"},   32'(a_bin),   32'(gray2bin(rq_of(0))));
    chk({tag, " a.fill"},  32'(a_fill),  32'(m_fill[0]));
    chk({tag, " a.empty"}, 32'(a_empty), 32'(m_empty[0]));
    chk({tag, " a.ae"},    32'(a_ae),    32'(m_ae[0]));
    chk({tag, " a.chg"},   32'(a_chg),   32'(m_chg[0]));
    chk({tag, " a.err"},   32'(a_err),   32'(m_err[0]));
    chk({tag, " b.gray"},  32'(b_gray),  32'(rq_of(1)));
    chk({tag, " b.bin"},   32'(b_bin),   32'(gray2bin(rq_of(1))));
    chk({tag, " b.fill"},  32'(b_fill),  32'(m_fill[1]));
    chk({tag, " b.empty"}, 32'(b_empty), 32'(m_empty[1]));
    chk({tag, " b.ae"},    32'(b_ae),    32'(m_ae[1]));
    chk({tag, " b.chg"},   32'(b_chg),   32'(m_chg[1]));
    chk({tag, " b.err"},   32'(b_err),   32'(m_err[1]));
  endtask

  // One rclk edge: model follows the edge, outputs are checked on the falling edge.
  task automatic tick(input string tag);
    @(posedge rclk);
    model_edge();
    @(negedge rclk);
    check_all(tag);
  endtask

  initial begin
    int r, n;
    rrst_n = 1'b0; wptr = 5'd0; rptr = 5'd0; err_clr = 1'b0; wbin = 5'd0;
    model_reset();
    repeat (2) @(negedge rclk);
    check_all("reset");
    chk("reset a.empty", 32'(a_empty), 32'd1);
    chk("reset a.ae", 32'(a_ae), 32'd1);
    rrst_n = 1'b1;

    // Latency: Gray(3) jump is a single bit change.
    wptr = 5'b00010;
    tick("lat e1");
    chk("lat e1 a.gray", 32'(a_gray), 32'd0);
    tick("lat e2");
    chk("lat e2 a.gray", 32'(a_gray), 32'b00010);
    chk("lat e2 a.bin", 32'(a_bin), 32'd3);
    tick("lat e3");
    chk("lat e3 a.fill", 32'(a_fill), 32'd3);
    chk("lat e3 a.empty", 32'(a_empty), 32'd0);
    chk("lat e3 a.ae", 32'(a_ae), 32'd0);
    chk("lat e3 a.chg", 32'(a_chg), 32'd1);
    chk("lat e3 a.err", 32'(a_err), 32'd0);
    chk("lat e3 b.gray", 32'(b_gray), 32'b00010);
    tick("lat e4");
    chk("lat e4 a.chg", 32'(a_chg), 32'd0);
    chk("lat e4 b.fill", 32'(b_fill), 32'd3);
    chk("lat e4 b.ae", 32'(b_ae), 32'd1);
    chk("lat e4 b.empty", 32'(b_empty), 32'd0);

    // Two-bit jump 0 -> Gray(2) must raise gray_err and hold it.
    wptr = 5'd0;
    repeat (4) tick("settle0");
    wptr = 5'b00011;
    repeat (3) tick("jump");
    chk("jump a.err", 32'(a_err), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick("sticky");
      chk("sticky a.err", 32'(a_err), 32'd1);
    end
    chk("sticky b.err", 32'(b_err), 32'd1);
    err_clr = 1'b1;
    tick("clr");
    chk("clr a.err", 32'(a_err), 32'd0);
    err_clr = 1'b0;

    // New violation (00011 -> 00000) on the same edge as err_clr: set wins.
    wptr = 5'd0;
    tick("sim e1");
    tick("sim e2");
    err_clr = 1'b1;
    tick("sim e3");
    chk("sim a.err", 32'(a_err), 32'd1);
    err_clr = 1'b0;
    tick("sim e4");
    chk("sim b.err", 32'(b_err), 32'd1);
    err_clr = 1'b1;
    tick("clr2");
    err_clr = 1'b0;
    tick("clr2b");

    // Wrap: Gray(31) -> Gray(0) with rptr=30.
    rptr = 5'd30; wptr = 5'b10000;
    repeat (4) tick("wrap pre");
    chk("wrap pre a.fill", 32'(a_fill), 32'd1);
    chk("wrap pre a.ae", 32'(a_ae), 32'd1);
    wptr = 5'b00000;
    repeat (3) tick("wrap");
    chk("wrap a.fill", 32'(a_fill), 32'd2);
    chk("wrap a.ae", 32'(a_ae), 32'd0);
    chk("wrap a.err", 32'(a_err), 32'd0);

    // Drain: write pointer at 7, read pointer steps 5, 6, 7.
    wptr = 5'b00100; rptr = 5'd5;
    repeat (4) tick("drain pre");
    chk("drain a.fill2", 32'(a_fill), 32'd2);
    rptr = 5'd6;
    tick("drain 6");
    chk("drain a.fill1", 32'(a_fill), 32'd1);
    chk("drain a.ae1", 32'(a_ae), 32'd1);
    chk("drain a.empty1", 32'(a_empty), 32'd0);
    rptr = 5'd7;
    tick("drain 7");
    chk("drain a.fill0", 32'(a_fill), 32'd0);
    chk("drain a.empty0", 32'(a_empty), 32'd1);

    // Mid-stream asynchronous reset with wptr = 01100.
    wptr = 5'b01100; rptr = 5'd0;
    repeat (2) tick("pre rst");
    #2;
    rrst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst async");
    chk("rst async a.gray", 32'(a_gray), 32'd0);
    chk("rst async a.empty", 32'(a_empty), 32'd1);
    tick("rst hold");
    rrst_n = 1'b1;
    tick("rst rel1");
    chk("rst rel1 a.empty", 32'(a_empty), 32'd1);
    tick("rst rel2");
    chk("rst rel2 a.empty", 32'(a_empty), 32'd1);
    chk("rst rel2 a.ae", 32'(a_ae), 32'd1);
    tick("rst rel3");
    chk("rst rel3 a.fill", 32'(a_fill), 32'd8);

    // Random phase: mostly legal Gray increments, occasional arbitrary jumps.
    wbin = gray2bin(wptr);
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        wptr = 5'($urandom_range(0, 31));
        wbin = gray2bin(wptr);
      end else if (r < 70) begin
        n = $urandom_range(0, 3);
        wbin = wbin + 5'(n);
        wptr = wbin ^ (wbin >> 1);
      end
      if ($urandom_range(0, 2) == 0) rptr = rptr + 5'($urandom_range(0, 2));
      err_clr = ($urandom_range(0, 9) == 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
